iq_cic_decim: RTL and testbench
===============================

# iq_cic_decim

Dual-channel (I and Q) 3-stage CIC decimator that consumes the 10-bit baseband I/Q sample stream and its one-cycle `dvalid` strobe from the RF front-end capture stage. It sits directly downstream of sample capture and upstream of demodulation. It reduces the 1 MS/s sample rate by `2**DECIM_LOG2` and provides the matching anti-alias response. Both channels share one decimation phase, so every output pair is time-aligned.

## Interface
- `IN_WIDTH`, 10: input sample width, signed two's complement.
- `DECIM_LOG2`, 3: log2 of decimation ratio R. Legal range 1..6.
- `OUT_WIDTH`, IN_WIDTH+3*DECIM_LOG2: output and internal width (full CIC bit growth). Derived; not overridden.
- `clk`  in  1  main clock (200 MHz in system).
- `reset`  in  1  asynchronous, active-high reset.
- `i_i`  in  IN_WIDTH  in-phase sample, signed.
- `q_i`  in  IN_WIDTH  quadrature sample, signed.
- `dvalid_i`  in  1  one-cycle strobe; `i_i`/`q_i` valid in that cycle.
- `i_o`  out  OUT_WIDTH  decimated in-phase output, signed.
- `q_o`  out  OUT_WIDTH  decimated quadrature output, signed.
- `dvalid_o`  out  1  one-cycle strobe; `i_o`/`q_o` valid in that cycle.

## Operation
- Per channel: 3 cascaded integrators at input rate, decimate by R, then 3 cascaded combs (differential delay M=1) at output rate.
- All integrator and comb arithmetic is OUT_WIDTH two's complement with modular wrap-around. No saturation. Wrap is intended and cancels in the combs.
- Inputs are sign-extended to OUT_WIDTH before the first integrator.
- Integrators update only on cycles with `dvalid_i`=1 and hold otherwise.
- Phase counter `ph` is DECIM_LOG2 bits, reset to 0. It increments on each `dvalid_i`. It wraps from R-1 to 0.
- A `dvalid_i` accepted with `ph`==R-1 is a decimation event. The third-integrator value, including that sample, enters the comb pipeline.
- Comb pipeline has 3 registered stages, one per comb. Each stage holds its previous input for the M=1 delay.
  - Comb delay registers update only when a decimation event passes through that stage.
  - Valid bits travel with the data.
- Pipeline is fully pipelined. Back-to-back `dvalid_i` every cycle is legal and loses no samples.
- DC gain is R^3 (512 at default). No output scaling.
- The I and Q paths are identical and share `ph` and the valid pipeline.

## Timing
- Reset (async assert, sync-released by the system): clears all integrators, comb delays, pipeline registers and `ph`. Outputs `i_o`=0, `q_o`=0, `dvalid_o`=0.
- Latency: `dvalid_o` is high exactly 4 clock edges after the edge that samples the decimation-event `dvalid_i`.
  - 1 edge for the integrators and 3 for the combs.
  - `i_o`/`q_o` are registered and hold their value until the next `dvalid_o`.
- `dvalid_o` is never high for two consecutive cycles unless R-th samples arrive 1 cycle apart. That is impossible for R≥2, so `dvalid_o` spacing is at least R cycles.
- Reset mid-operation: in-flight decimation events are discarded, with no `dvalid_o` after reset. The first output after reset follows the R-th post-reset `dvalid_i`.
- `dvalid_i` high during reset is ignored.

## Test plan
- Impulse, default params: `i_i`=1 on the first post-reset `dvalid_i`, then 0. Expect the first three `i_o` values to be 36, 28, 0, with `q_o`=0 throughout.
- DC: `i_i`=511 and `q_i`=-512 on every `dvalid_i`. Expect the fourth and later outputs `i_o`=261632 and `q_o`=-262144. Confirms no loss from wrap and full-range growth.
- Timing: `dvalid_i` every 200 cycles. Expect `dvalid_o` every 1600 cycles, each exactly 4 cycles after the 8th/16th/... `dvalid_i`, and one cycle wide.
- Back-to-back: `dvalid_i` held high continuously with a ramp input. Expect `dvalid_o` every 8 cycles, with outputs bit-exact against a software CIC model.
- Reset mid-flight: assert `reset` 2 cycles after a decimation-event `dvalid_i`. Expect no `dvalid_o` from that event, all outputs 0, and the next `dvalid_o` 4 cycles after the 8th post-reset `dvalid_i`.
- Long random run: 10^5 random signed samples with random 1–300 cycle spacing, at DECIM_LOG2=3 and DECIM_LOG2=6. Expect bit-exact match to the reference model on both channels.

Source files
------------

// File: rtl/iq_cic_decim.sv
// Dual-channel (I/Q) 3-stage CIC decimator by 2**DECIM_LOG2 with full bit growth.
// Chained integrators at input rate, a decimation register, then three registered combs (M=1).
module iq_cic_decim #(
  parameter int IN_WIDTH   = 10,
  parameter int DECIM_LOG2 = 3,
  parameter int OUT_WIDTH  = IN_WIDTH + 3 * DECIM_LOG2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  i_i,
  input  logic [IN_WIDTH-1:0]  q_i,
  input  logic                 dvalid_i,
  output logic [OUT_WIDTH-1:0] i_o,
  output logic [OUT_WIDTH-1:0] q_o,
  output logic                 dvalid_o
);

  localparam int W = OUT_WIDTH;

  logic [W-1:0] x_ext  [2];
  logic [W-1:0] int1_d [2];
  logic [W-1:0] int2_d [2];
  logic [W-1:0] int3_d [2];
  logic [W-1:0] int1_q [2];
  logic [W-1:0] int2_q [2];
  logic [W-1:0] int3_q [2];
  logic [W-1:0] dec_q  [2];
  logic [W-1:0] c1_q   [2];
  logic [W-1:0] c1_dly_q [2];
  logic [W-1:0] c2_q   [2];
  logic [W-1:0] c2_dly_q [2];
  logic [W-1:0] c3_q   [2];
  logic [W-1:0] c3_dly_q [2];

  logic [DECIM_LOG2-1:0] ph_q;
  logic ev_q, v1_q, v2_q, v3_q, v4_q;

  // Integrators are chained combinationally so the third one includes the current sample.
  always_comb begin
    x_ext[0] = {{(W-IN_WIDTH){i_i[IN_WIDTH-1]}}, i_i};
    x_ext[1] = {{(W-IN_WIDTH){q_i[IN_WIDTH-1]}}, q_i};
    for (int c = 0; c < 2; c++) begin
      int1_d[c] = int1_q[c] + x_ext[c];
      int2_d[c] = int2_q[c] + int1_d[c];
      int3_d[c] = int3_q[c] + int2_d[c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q <= '0;
      ev_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      v4_q <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        int1_q[c]   <= '0;
        int2_q[c]   <= '0;
        int3_q[c]   <= '0;
        dec_q[c]    <= '0;
        c1_q[c]     <= '0;
        c1_dly_q[c] <= '0;
        c2_q[c]     <= '0;
        c2_dly_q[c] <= '0;
        c3_q[c]     <= '0;
        c3_dly_q[c] <= '0;
      end
    end else begin
      ev_q <= dvalid_i && (ph_q == '1);
      v1_q <= ev_q;
      v2_q <= v1_q;
      v3_q <= v2_q;
      v4_q <= v3_q;
      if (dvalid_i) begin
        ph_q <= ph_q + DECIM_LOG2'(1);
      end
      for (int c = 0; c < 2; c++) begin
        if (dvalid_i) begin
          int1_q[c] <= int1_d[c];
          int2_q[c] <= int2_d[c];
          int3_q[c] <= int3_d[c];
        end
        if (ev_q) begin
          dec_q[c] <= int3_q[c];
        end
        // Comb delays advance only when a decimated sample passes through.
        if (v1_q) begin
          c1_q[c]     <= dec_q[c] - c1_dly_q[c];
          c1_dly_q[c] <= dec_q[c];
        end
        if (v2_q) begin
          c2_q[c]     <= c1_q[c] - c2_dly_q[c];
          c2_dly_q[c] <= c1_q[c];
        end
        if (v3_q) begin
          c3_q[c]     <= c2_q[c] - c3_dly_q[c];
          c3_dly_q[c] <= c2_q[c];
        end
      end
    end
  end

  assign i_o      = c3_q[0];
  assign q_o      = c3_q[1];
  assign dvalid_o = v4_q;

endmodule

// File: tb/tb_iq_cic_decim.sv
// Directed bench for iq_cic_decim at default parameters (R=8, 19-bit output).
// Hand-computed values for impulse/DC/reset cases; a small CIC model for ramp and random cases.
module tb_iq_cic_decim;

  localparam int IW = 10;
  localparam int DL = 3;
  localparam int OW = IW + 3 * DL;
  localparam int R  = 1 << DL;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [IW-1:0] i_i = '0;
  logic [IW-1:0] q_i = '0;
  logic          dvalid_i = 1'b0;
  logic [OW-1:0] i_o, q_o;
  logic          dvalid_o;

  iq_cic_decim #(.IN_WIDTH(IW), .DECIM_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .i_i(i_i), .q_i(q_i), .dvalid_i(dvalid_i),
    .i_o(i_o), .q_o(q_o), .dvalid_o(dvalid_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  longint cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Observed outputs and model expectations
  longint oq_i[$], oq_q[$], oq_c[$];
  longint eq_i[$], eq_q[$], eq_c[$];
  logic   prev_dv = 1'b0;

  always @(negedge clk) begin
    if (dvalid_o) begin
      check("dv_width", longint'(prev_dv), 0);
      oq_i.push_back(longint'($signed(i_o)));
      oq_q.push_back(longint'($signed(q_o)));
      oq_c.push_back(cyc);
    end
    prev_dv = dvalid_o;
  end

  // Reference CIC state, 19-bit modular
  logic signed [OW-1:0] m_a1[2], m_a2[2], m_a3[2], m_d1[2], m_d2[2], m_d3[2];
  int m_cnt = 0;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_a1[c] = '0; m_a2[c] = '0; m_a3[c] = '0;
      m_d1[c] = '0; m_d2[c] = '0; m_d3[c] = '0;
    end
    m_cnt = 0;
    oq_i.delete(); oq_q.delete(); oq_c.delete();
    eq_i.delete(); eq_q.delete(); eq_c.delete();
  endtask

  task automatic send(input int xi, input int xq, input int gap);
    logic signed [IW-1:0] s10;
    logic signed [OW-1:0] x, c1, c2, c3;
    longint res[2];
    i_i = xi[IW-1:0];
    q_i = xq[IW-1:0];
    dvalid_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      s10 = (c == 0) ? xi[IW-1:0] : xq[IW-1:0];
      x = OW'(s10);
      m_a1[c] = m_a1[c] + x;
      m_a2[c] = m_a2[c] + m_a1[c];
      m_a3[c] = m_a3[c] + m_a2[c];
      res[c] = 0;
    end
    m_cnt++;
    @(posedge clk); #1;
    dvalid_i = 1'b0;
    if (m_cnt % R == 0) begin
      for (int c = 0; c < 2; c++) begin
        c1 = m_a3[c] - m_d1[c]; m_d1[c] = m_a3[c];
        c2 = c1 - m_d2[c];      m_d2[c] = c1;
        c3 = c2 - m_d3[c];      m_d3[c] = c2;
        res[c] = longint'(c3);
      end
      eq_i.push_back(res[0]);
      eq_q.push_back(res[1]);
      eq_c.push_back(cyc);
    end
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input logic dv_during);
    @(posedge clk); #1;
    reset = 1'b1;
    dvalid_i = dv_during;
    i_i = 10'd7;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    dvalid_i = 1'b0;
    model_reset();
  endtask

  task automatic settle(input string tag, input int n);
    repeat (12) begin
      @(posedge clk); #1;
    end
    check({tag, "_count"}, longint'(oq_i.size()), longint'(n));
  endtask

  task automatic compare_model(input string tag);
    int n;
    n = (oq_i.size() < eq_i.size()) ? oq_i.size() : eq_i.size();
    for (int k = 0; k < n; k++) begin
      check({tag, "_i"}, oq_i[k], eq_i[k]);
      check({tag, "_q"}, oq_q[k], eq_q[k]);
      check({tag, "_lat"}, oq_c[k] - eq_c[k], 4);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_i", longint'($signed(i_o)), 0);
    check("rst_q", longint'($signed(q_o)), 0);
    check("rst_dv", longint'(dvalid_o), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Impulse on I
    send(1, 0, 3);
    for (int k = 1; k < 3 * R; k++) send(0, 0, 3);
    settle("imp", 3);
    if (oq_i.size() >= 3) begin
      check("imp_i0", oq_i[0], 36);
      check("imp_i1", oq_i[1], 28);
      check("imp_i2", oq_i[2], 0);
      check("imp_q0", oq_q[0], 0);
      check("imp_q1", oq_q[1], 0);
      check("imp_q2", oq_q[2], 0);
    end
    compare_model("imp");

    // Full-scale DC
    do_reset(1'b0);
    for (int k = 0; k < 5 * R; k++) send(511, -512, 2);
    settle("dc", 5);
    if (oq_i.size() >= 5) begin
      check("dc_i4", oq_i[3], 261632);
      check("dc_q4", oq_q[3], -262144);
      check("dc_i5", oq_i[4], 261632);
      check("dc_q5", oq_q[4], -262144);
    end
    compare_model("dc");

    // Sparse input spacing
    do_reset(1'b0);
    for (int k = 0; k < 2 * R; k++) send(k * 3 - 20, 17 - k, 200);
    settle("tim", 2);
    if (oq_c.size() >= 2) check("tim_space", oq_c[1] - oq_c[0], 1600);
    compare_model("tim");

    // Back-to-back ramp
    do_reset(1'b0);
    for (int k = 0; k < 8 * R; k++) send(k - 32, -k, 1);
    settle("b2b", 8);
    if (oq_c.size() >= 2) check("b2b_space", oq_c[1] - oq_c[0], 8);
    compare_model("b2b");

    // Reset two cycles after a decimation event; dvalid_i held during reset
    do_reset(1'b0);
    for (int k = 0; k < R; k++) send(5, -3, 1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    dvalid_i = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dvalid_i = 1'b0;
    model_reset();
    check("mid_i", longint'($signed(i_o)), 0);
    check("mid_q", longint'($signed(q_o)), 0);
    settle("mid_none", 0);
    for (int k = 0; k < R; k++) send(5, -3, 2);
    settle("mid", 1);
    if (oq_i.size() >= 1) begin
      check("mid_i1", oq_i[0], 600);
      check("mid_q1", oq_q[0], -360);
    end
    compare_model("mid");

    // Random samples and spacing
    do_reset(1'b0);
    for (int k = 0; k < 50 * R; k++)
      send(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
           int'($urandom_range(1, 4)));
    settle("rnd", 50);
    compare_model("rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
